// File: rtl/weight_row_reader.sv
// Streams one row of the row-major weight RAM to the neuron pipeline over valid/ready.
// RAM reads are issued only when the output FIFO has a free slot for the returning word.
module weight_row_reader #(
    parameter int unsigned WORD_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 25,
    parameter int unsigned NUM_ROWS   = 4,
    parameter int unsigned NUM_COLS   = 6,
    parameter int unsigned ROW_WIDTH  = 2,
    parameter int unsigned COL_WIDTH  = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  RowRequest,
    input  logic [ROW_WIDTH-1:0]  RowIndex,
    output logic                  RowReady,
    output logic                  RamChipEnable,
    output logic                  RamWriteEnable,
    output logic [ADDR_WIDTH-1:0] RamAddress,
    input  logic [WORD_WIDTH-1:0] RamData,
    output logic                  WeightValid,
    output logic [WORD_WIDTH-1:0] WeightData,
    output logic [COL_WIDTH-1:0]  WeightColumn,
    output logic                  WeightLast,
    input  logic                  WeightReady,
    output logic                  Done
);

    localparam int unsigned CNT_W = $clog2(NUM_COLS + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] data;
        logic [COL_WIDTH-1:0]  col;
        logic                  last;
    } entry_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [CNT_W-1:0]      col_q, col_d;
    logic                  issue_q, issue_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  inflight_q, inflight_d;
    logic [COL_WIDTH-1:0]  infl_col_q, infl_col_d;
    entry_t                mem_q [FIFO_DEPTH];
    entry_t                mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      count_q, count_d;
    entry_t                head_q, head_d;
    logic                  valid_q, valid_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;
    logic                  push, pop;
    entry_t                new_entry;

    // Next-state: FSM, address counter, FIFO and the one-cycle lookahead for RAM outputs.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        col_d      = col_q;
        inflight_d = issue_q;
        infl_col_d = infl_col_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        done_d     = 1'b0;
        push       = inflight_q;
        pop        = valid_q && WeightReady;

        new_entry.data = RamData;
        new_entry.col  = infl_col_q;
        new_entry.last = (infl_col_q == COL_WIDTH'(NUM_COLS - 1));

        if (issue_q) begin
            col_d      = col_q + CNT_W'(1);
            infl_col_d = COL_WIDTH'(col_q);
        end

        case (state_q)
            IDLE: begin
                if (RowRequest) begin
                    state_d = FETCH;
                    base_d  = ADDR_WIDTH'(RowIndex) * ADDR_WIDTH'(NUM_COLS);
                    col_d   = '0;
                end
            end
            FETCH: begin
                if (issue_q && (col_q == CNT_W'(NUM_COLS - 1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && head_q.last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            mem_d[wr_ptr_q] = new_entry;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + LVL_W'(push) - LVL_W'(pop);

        valid_d = (count_d != '0);
        head_d  = mem_d[rd_ptr_d];
        ready_d = (state_d == IDLE);

        // Credit check covers the word already in flight so a push never meets a full FIFO.
        issue_d = (state_d == FETCH) && (col_d < CNT_W'(NUM_COLS))
               && ((count_d + LVL_W'(inflight_d)) < LVL_W'(FIFO_DEPTH));
        addr_d  = issue_d ? (base_d + ADDR_WIDTH'(col_d)) : addr_q;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            col_q      <= '0;
            issue_q    <= 1'b0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            infl_col_q <= '0;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            head_q     <= '0;
            valid_q    <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            col_q      <= col_d;
            issue_q    <= issue_d;
            addr_q     <= addr_d;
            inflight_q <= inflight_d;
            infl_col_q <= infl_col_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            head_q     <= head_d;
            valid_q    <= valid_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
        end
    end

    assign RowReady       = ready_q;
    assign RamChipEnable  = issue_q;
    assign RamWriteEnable = 1'b0;
    assign RamAddress     = addr_q;
    assign WeightValid    = valid_q;
    assign WeightData     = head_q.data;
    assign WeightColumn   = head_q.col;
    assign WeightLast     = head_q.last;
    assign Done           = done_q;

endmodule
